// File: rtl/eth_tx_pkg.sv
// Shared constants for the Ethernet MAC transmit path.
package eth_tx_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] EXDFR_LIMIT_DFLT   = 16'h17B7;
    localparam logic [2:0]       DLY_CRC_BYTES_DFLT = 3'd4;

endpackage

// File: rtl/eth_txcounters.sv
// Transmit nibble, byte and delayed-CRC counters with the comparisons
// that steer the transmit state machine.
module eth_txcounters
    import eth_tx_pkg::*;
#(
    parameter logic [CNT_W-1:0] EXDFR_LIMIT   = EXDFR_LIMIT_DFLT,
    parameter logic [2:0]       DLY_CRC_BYTES = DLY_CRC_BYTES_DFLT
) (
    input  logic             MTxClk,
    input  logic             Reset,
    input  logic             StateIdle,
    input  logic             StateIPG,
    input  logic             StatePreamble,
    input  logic [1:0]       StateData,
    input  logic             StatePAD,
    input  logic             StateFCS,
    input  logic             StateJam,
    input  logic             StateBackOff,
    input  logic             StateDefer,
    input  logic             StartDefer,
    input  logic             StartIPG,
    input  logic             StartFCS,
    input  logic             StartJam,
    input  logic             StartBackoff,
    input  logic             TxStartFrm,
    input  logic             PacketFinished_q,
    input  logic [CNT_W-1:0] MinFL,
    input  logic [CNT_W-1:0] MaxFL,
    input  logic             HugEn,
    input  logic             ExDfrEn,
    input  logic             DlyCrcEn,
    output logic [CNT_W-1:0] NibCnt,
    output logic [CNT_W-1:0] ByteCnt,
    output logic [2:0]       DlyCrcCnt,
    output logic             NibCntEq7,
    output logic             NibCntEq15,
    output logic             NibbleMinFl,
    output logic             ExcessiveDefer,
    output logic             MaxFrame
);

    logic [CNT_W-1:0] nib_cnt_d, nib_cnt_q;
    logic [CNT_W-1:0] byte_cnt_d, byte_cnt_q;
    logic [2:0]       dly_crc_cnt_d, dly_crc_cnt_q;
    logic [CNT_W:0]   min_nib;
    logic             nib_clr, nib_inc;
    logic             byte_clr, byte_inc;
    logic             dly_full;

    assign NibCnt    = nib_cnt_q;
    assign ByteCnt   = byte_cnt_q;
    assign DlyCrcCnt = dly_crc_cnt_q;

    // Threshold 2*(MinFL-4)-1, compared signed so small MinFL goes negative.
    assign min_nib = {MinFL, 1'b0} - 17'd9;

    always_comb begin
        NibCntEq7      = (nib_cnt_q[2:0] == 3'd7);
        NibCntEq15     = (nib_cnt_q[3:0] == 4'd15);
        NibbleMinFl    = (MinFL < 16'd5) |
                         ($signed({1'b0, nib_cnt_q}) >= $signed(min_nib));
        ExcessiveDefer = StateDefer & (nib_cnt_q == EXDFR_LIMIT) & ~ExDfrEn;
        MaxFrame       = (byte_cnt_q == MaxFL) & ~HugEn;
    end

    always_comb begin
        nib_clr = StateIdle | StartDefer | StartIPG | StartFCS | StartJam |
                  (StatePreamble & NibCntEq15) |
                  (StateJam & NibCntEq7) |
                  (StateDefer & ExcessiveDefer & ~TxStartFrm);
        nib_inc = StateIPG | StatePreamble | (|StateData) | StatePAD |
                  StateFCS | StateJam | StateBackOff |
                  (StateDefer & ~ExcessiveDefer & TxStartFrm);
        nib_cnt_d = nib_cnt_q;
        if (nib_clr)
            nib_cnt_d = '0;
        else if (nib_inc)
            nib_cnt_d = nib_cnt_q + 16'd1;
    end

    always_comb begin
        dly_full      = (dly_crc_cnt_q == DLY_CRC_BYTES);
        dly_crc_cnt_d = dly_crc_cnt_q;
        if (StartJam | PacketFinished_q)
            dly_crc_cnt_d = '0;
        else if (StateData[1] & DlyCrcEn & (dly_crc_cnt_q < DLY_CRC_BYTES))
            dly_crc_cnt_d = dly_crc_cnt_q + 3'd1;
    end

    // Backoff slots are counted every 128 nibbles.
    always_comb begin
        byte_clr = StartBackoff | StartDefer;
        byte_inc = (StateData[1] & (~DlyCrcEn | dly_full)) |
                   ((StatePAD | StateFCS) & nib_cnt_q[0]) |
                   (StateBackOff & (nib_cnt_q[6:0] == 7'h7F));
        byte_cnt_d = byte_cnt_q;
        if (byte_clr)
            byte_cnt_d = '0;
        else if (byte_inc & (byte_cnt_q != 16'hFFFF))
            byte_cnt_d = byte_cnt_q + 16'd1;
    end

    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset)
            nib_cnt_q <= '0;
        else
            nib_cnt_q <= nib_cnt_d;
    end

    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset)
            byte_cnt_q <= '0;
        else
            byte_cnt_q <= byte_cnt_d;
    end

    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset)
            dly_crc_cnt_q <= '0;
        else
            dly_crc_cnt_q <= dly_crc_cnt_d;
    end

endmodule

// File: tb/tb_eth_txcounters.sv
// Self-checking bench for eth_txcounters against a behavioural model.
module tb_eth_txcounters;

    logic        MTxClk, Reset;
    logic        StateIdle, StateIPG, StatePreamble, StatePAD, StateFCS;
    logic        StateJam, StateBackOff, StateDefer;
    logic [1:0]  StateData;
    logic        StartDefer, StartIPG, StartFCS, StartJam, StartBackoff;
    logic        TxStartFrm, PacketFinished_q;
    logic [15:0] MinFL, MaxFL;
    logic        HugEn, ExDfrEn, DlyCrcEn;
    logic [15:0] NibCnt, ByteCnt;
    logic [2:0]  DlyCrcCnt;
    logic        NibCntEq7, NibCntEq15, NibbleMinFl, ExcessiveDefer, MaxFrame;

    int checks = 0;
    int errors = 0;

    int m_nib, m_byte, m_dly;

    eth_txcounters dut (
        .MTxClk(MTxClk), .Reset(Reset),
        .StateIdle(StateIdle), .StateIPG(StateIPG),
        .StatePreamble(StatePreamble), .StateData(StateData),
        .StatePAD(StatePAD), .StateFCS(StateFCS), .StateJam(StateJam),
        .StateBackOff(StateBackOff), .StateDefer(StateDefer),
        .StartDefer(StartDefer), .StartIPG(StartIPG),
        .StartFCS(StartFCS), .StartJam(StartJam),
        .StartBackoff(StartBackoff), .TxStartFrm(TxStartFrm),
        .PacketFinished_q(PacketFinished_q),
        .MinFL(MinFL), .MaxFL(MaxFL), .HugEn(HugEn),
        .ExDfrEn(ExDfrEn), .DlyCrcEn(DlyCrcEn),
        .NibCnt(NibCnt), .ByteCnt(ByteCnt), .DlyCrcCnt(DlyCrcCnt),
        .NibCntEq7(NibCntEq7), .NibCntEq15(NibCntEq15),
        .NibbleMinFl(NibbleMinFl), .ExcessiveDefer(ExcessiveDefer),
        .MaxFrame(MaxFrame)
    );

    initial MTxClk = 1'b0;
    always #5 MTxClk = ~MTxClk;

    // Reference model: counters as plain integers, rules taken directly
    // from the block description.
    function automatic bit f_exd();
        return StateDefer && (m_nib == 6071) && !ExDfrEn;
    endfunction

    function automatic bit f_minfl();
        int t;
        if (MinFL < 5) return 1'b1;
        t = (2 * (int'(MinFL) - 4) - 1) & 32'h1FFFF;
        if (t >= 65536) t = t - 131072;
        return m_nib >= t;
    endfunction

    function automatic bit f_maxf();
        return (m_byte == int'(MaxFL)) && !HugEn;
    endfunction

    always @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            m_nib  <= 0;
            m_byte <= 0;
            m_dly  <= 0;
        end else begin
            if (StateIdle || StartDefer || StartIPG || StartFCS || StartJam ||
                (StatePreamble && m_nib % 16 == 15) ||
                (StateJam && m_nib % 8 == 7) ||
                (StateDefer && f_exd() && !TxStartFrm))
                m_nib <= 0;
            else if (StateIPG || StatePreamble || StateData != 2'b00 ||
                     StatePAD || StateFCS || StateJam || StateBackOff ||
                     (StateDefer && !f_exd() && TxStartFrm))
                m_nib <= (m_nib + 1) % 65536;

            if (StartJam || PacketFinished_q)
                m_dly <= 0;
            else if (StateData[1] && DlyCrcEn && m_dly < 4)
                m_dly <= m_dly + 1;

            if (StartBackoff || StartDefer)
                m_byte <= 0;
            else if (m_byte < 65535 &&
                     ((StateData[1] && (!DlyCrcEn || m_dly == 4)) ||
                      ((StatePAD || StateFCS) && m_nib % 2 == 1) ||
                      (StateBackOff && m_nib % 128 == 127)))
                m_byte <= m_byte + 1;
        end
    end

    task automatic idle_in();
        StateIdle = 0; StateIPG = 0; StatePreamble = 0; StatePAD = 0;
        StateFCS = 0; StateJam = 0; StateBackOff = 0; StateDefer = 0;
        StateData = 2'b00;
        StartDefer = 0; StartIPG = 0; StartFCS = 0; StartJam = 0;
        StartBackoff = 0; TxStartFrm = 0; PacketFinished_q = 0;
    endtask

    task automatic step();
        @(posedge MTxClk);
        #1;
    endtask

    task automatic clear_cycle();
        idle_in();
        StateIdle = 1; StartDefer = 1; PacketFinished_q = 1;
        @(negedge MTxClk);
        step();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        Reset = 1; MinFL = 16'd64; MaxFL = 16'd1518;
        HugEn = 0; ExDfrEn = 0; DlyCrcEn = 0;
        @(negedge MTxClk);
        checks++;
        if (NibCnt !== 16'd0 || ByteCnt !== 16'd0 || DlyCrcCnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt nib=%0d byte=%0d dly=%0d want 0",
                     NibCnt, ByteCnt, DlyCrcCnt);
        end
        checks++;
        if (NibbleMinFl !== 1'b0 || NibCntEq7 !== 1'b0 || MaxFrame !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmp minfl=%b eq7=%b maxf=%b want 0",
                     NibbleMinFl, NibCntEq7, MaxFrame);
        end
        step();
        Reset = 0;
    endtask

    task automatic test_preamble();
        idle_in();
        StateIdle = 1;
        @(negedge MTxClk);
        step();
        idle_in();
        StatePreamble = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge MTxClk);
            checks++;
            if (NibCnt !== 16'(i) || NibCntEq15 !== (i == 15)) begin
                errors++;
                $display("FAIL preamble_%0d nib=%0d eq15=%b want %0d %b",
                         i, NibCnt, NibCntEq15, i, i == 15);
            end
            step();
        end
        idle_in();
        StateData = 2'b01;
        @(negedge MTxClk);
        checks++;
        if (NibCnt !== 16'd0) begin
            errors++;
            $display("FAIL preamble_data nib=%0d want 0", NibCnt);
        end
        step();
    endtask

    task automatic test_min_pad();
        bit rose = 0;
        MinFL = 16'd64; DlyCrcEn = 0;
        clear_cycle();
        for (int i = 0; i < 20; i++) begin
            StateData = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge MTxClk);
            step();
        end
        idle_in();
        StatePAD = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge MTxClk);
            if (NibbleMinFl) begin
                rose = 1;
                break;
            end
            step();
        end
        checks++;
        if (!rose || NibCnt !== 16'd119) begin
            errors++;
            $display("FAIL minfl_rise rose=%b nib=%0d want 1 119", rose, NibCnt);
        end
        checks++;
        if (int'(ByteCnt) != m_byte) begin
            errors++;
            $display("FAIL minfl_byte byte=%0d want %0d", ByteCnt, m_byte);
        end
        step();
        @(negedge MTxClk);
        checks++;
        if (ByteCnt !== 16'd60) begin
            errors++;
            $display("FAIL minfl_byte60 byte=%0d want 60", ByteCnt);
        end
        step();
    endtask

    task automatic test_max_frame();
        bit hit = 0;
        bit bad = 0;
        MaxFL = 16'd1518; HugEn = 0; DlyCrcEn = 0;
        clear_cycle();
        for (int i = 0; i < 4000; i++) begin
            StateData = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge MTxClk);
            if (MaxFrame) begin
                hit = 1;
                break;
            end
            step();
        end
        checks++;
        if (!hit || ByteCnt !== 16'd1518) begin
            errors++;
            $display("FAIL maxframe hit=%b byte=%0d want 1 1518", hit, ByteCnt);
        end
        step();
        HugEn = 1;
        clear_cycle();
        for (int i = 0; i < 3038; i++) begin
            StateData = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge MTxClk);
            if (MaxFrame) bad = 1;
            step();
        end
        idle_in();
        @(negedge MTxClk);
        checks++;
        if (bad || ByteCnt !== 16'd1519) begin
            errors++;
            $display("FAIL hugen maxf_seen=%b byte=%0d want 0 1519", bad, ByteCnt);
        end
        step();
        HugEn = 0;
    endtask

    task automatic test_exdefer();
        bit hit = 0;
        bit bad = 0;
        ExDfrEn = 0;
        clear_cycle();
        StateDefer = 1; TxStartFrm = 1;
        for (int i = 0; i < 7000; i++) begin
            @(negedge MTxClk);
            if (ExcessiveDefer) begin
                hit = 1;
                break;
            end
            step();
        end
        checks++;
        if (!hit || NibCnt !== 16'h17B7) begin
            errors++;
            $display("FAIL exdefer hit=%b nib=%h want 1 17b7", hit, NibCnt);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge MTxClk);
            checks++;
            if (NibCnt !== 16'h17B7 || ExcessiveDefer !== 1'b1) begin
                errors++;
                $display("FAIL exdefer_hold nib=%h exd=%b want 17b7 1",
                         NibCnt, ExcessiveDefer);
            end
        end
        step();
        TxStartFrm = 0;
        @(negedge MTxClk);
        step();
        @(negedge MTxClk);
        checks++;
        if (NibCnt !== 16'd0) begin
            errors++;
            $display("FAIL exdefer_drop nib=%0d want 0", NibCnt);
        end
        step();
        ExDfrEn = 1; TxStartFrm = 1;
        for (int i = 0; i < 6080; i++) begin
            @(negedge MTxClk);
            if (ExcessiveDefer) bad = 1;
            step();
        end
        @(negedge MTxClk);
        checks++;
        if (bad || NibCnt !== 16'd6080) begin
            errors++;
            $display("FAIL exdfren exd_seen=%b nib=%0d want 0 6080", bad, NibCnt);
        end
        step();
        ExDfrEn = 0;
        idle_in();
    endtask

    task automatic test_dly_crc();
        DlyCrcEn = 1;
        clear_cycle();
        for (int i = 0; i < 8; i++) begin
            StateData = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge MTxClk);
            step();
        end
        idle_in();
        @(negedge MTxClk);
        checks++;
        if (DlyCrcCnt !== 3'd4 || ByteCnt !== 16'd0) begin
            errors++;
            $display("FAIL dlycrc_4 dly=%0d byte=%0d want 4 0", DlyCrcCnt, ByteCnt);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            StateData = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge MTxClk);
            step();
        end
        idle_in();
        @(negedge MTxClk);
        checks++;
        if (DlyCrcCnt !== 3'd4 || ByteCnt !== 16'd2) begin
            errors++;
            $display("FAIL dlycrc_6 dly=%0d byte=%0d want 4 2", DlyCrcCnt, ByteCnt);
        end
        step();
        PacketFinished_q = 1;
        @(negedge MTxClk);
        step();
        PacketFinished_q = 0;
        @(negedge MTxClk);
        checks++;
        if (DlyCrcCnt !== 3'd0) begin
            errors++;
            $display("FAIL dlycrc_fin dly=%0d want 0", DlyCrcCnt);
        end
        step();
    endtask

    task automatic test_clear_vs_inc();
        int b;
        DlyCrcEn = 1;
        StateData = 2'b01;
        @(negedge MTxClk);
        step();
        StateData = 2'b10;
        @(negedge MTxClk);
        step();
        b = int'(ByteCnt);
        StateData = 2'b10; StartJam = 1;
        @(negedge MTxClk);
        step();
        idle_in();
        @(negedge MTxClk);
        checks++;
        if (int'(ByteCnt) != b || NibCnt !== 16'd0 || DlyCrcCnt !== 3'd0) begin
            errors++;
            $display("FAIL jam_vs_data byte=%0d nib=%0d dly=%0d want %0d 0 0",
                     ByteCnt, NibCnt, DlyCrcCnt, b);
        end
        step();
        DlyCrcEn = 0;
        StateData = 2'b10; StartBackoff = 1;
        @(negedge MTxClk);
        step();
        idle_in();
        @(negedge MTxClk);
        checks++;
        if (ByteCnt !== 16'd0) begin
            errors++;
            $display("FAIL backoff_vs_data byte=%0d want 0", ByteCnt);
        end
        step();
    endtask

    task automatic test_async_reset();
        idle_in();
        StateFCS = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge MTxClk);
            step();
        end
        #2;
        Reset = 1;
        #1;
        checks++;
        if (NibCnt !== 16'd0 || ByteCnt !== 16'd0 || DlyCrcCnt !== 3'd0) begin
            errors++;
            $display("FAIL async_reset nib=%0d byte=%0d dly=%0d want 0",
                     NibCnt, ByteCnt, DlyCrcCnt);
        end
        step();
        Reset = 0;
        @(negedge MTxClk);
        step();
        @(negedge MTxClk);
        checks++;
        if (NibCnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_resume nib=%0d want 1", NibCnt);
        end
        step();
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            sel = $urandom_range(0, 10);
            case (sel)
                0: StateIdle = 1;
                1: StateIPG = 1;
                2: StatePreamble = 1;
                3: StateData = 2'b01;
                4: StateData = 2'b10;
                5: StatePAD = 1;
                6: StateFCS = 1;
                7: StateJam = 1;
                8: StateBackOff = 1;
                default: StateDefer = 1;
            endcase
            StartDefer       = ($urandom_range(0, 31) == 0);
            StartIPG         = ($urandom_range(0, 31) == 0);
            StartFCS         = ($urandom_range(0, 31) == 0);
            StartJam         = ($urandom_range(0, 31) == 0);
            StartBackoff     = ($urandom_range(0, 31) == 0);
            PacketFinished_q = ($urandom_range(0, 15) == 0);
            TxStartFrm       = ($urandom_range(0, 3) != 0);
            if (i % 100 == 0) begin
                MinFL    = 16'($urandom_range(0, 40));
                MaxFL    = 16'($urandom_range(0, 30));
                HugEn    = ($urandom_range(0, 3) == 0);
                DlyCrcEn = $urandom_range(0, 1) == 1;
                ExDfrEn  = $urandom_range(0, 1) == 1;
            end
            @(negedge MTxClk);
            checks++;
            if (int'(NibCnt) != m_nib || int'(ByteCnt) != m_byte ||
                int'(DlyCrcCnt) != m_dly) begin
                errors++;
                $display("FAIL rnd_cnt_%0d nib=%0d byte=%0d dly=%0d want %0d %0d %0d",
                         i, NibCnt, ByteCnt, DlyCrcCnt, m_nib, m_byte, m_dly);
            end
            checks++;
            if (NibCntEq7 !== (m_nib % 8 == 7) || NibCntEq15 !== (m_nib % 16 == 15) ||
                NibbleMinFl !== f_minfl() || ExcessiveDefer !== f_exd() ||
                MaxFrame !== f_maxf()) begin
                errors++;
                $display("FAIL rnd_cmp_%0d eq7=%b eq15=%b minfl=%b exd=%b maxf=%b want %b %b %b %b %b",
                         i, NibCntEq7, NibCntEq15, NibbleMinFl, ExcessiveDefer,
                         MaxFrame, m_nib % 8 == 7, m_nib % 16 == 15, f_minfl(),
                         f_exd(), f_maxf());
            end
            step();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_min_pad();
        test_max_frame();
        test_exdefer();
        test_dly_crc();
        test_clear_vs_inc();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
